// File: rtl/logic_eval_pipe_if.sv
// Handshake and data bundle for logic_eval_pipe: operand side (a/b/c/mode)
// and result side (x/y plus optional parity), each with valid/ready.
`timescale 1ns/1ps
interface logic_eval_pipe_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         x_par;
  logic         y_par;

  modport master (
    output in_valid, a, b, c, mode, out_ready,
    input  in_ready, out_valid, x, y, x_par, y_par
  );

  modport slave (
    input  in_valid, a, b, c, mode, out_ready,
    output in_ready, out_valid, x, y, x_par, y_par
  );
endinterface

// File: rtl/logic_eval_pipe.sv
// Two-stage valid/ready pipeline evaluating a mode-selected pair of bitwise
// functions, with a saturating ones counter on x. Parity outputs: LOGIC_EVAL_PARITY_EN.
`timescale 1ns/1ps
module logic_eval_pipe #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_eval_pipe_if.slave     bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     x_ones_cnt
);

  typedef enum logic [1:0] {
    MODE_XNOR_OR = 2'd0,
    MODE_AND_XOR = 2'd1,
    MODE_MAJ     = 2'd2,
    MODE_NOR     = 2'd3
  } mode_e;

  localparam int unsigned PC_W  = $clog2(W + 1);
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic         s1_valid;
  logic [W-1:0] s1_a, s1_b, s1_c;
  mode_e        s1_mode;

  logic         out_valid_q;
  logic [W-1:0] x_q, y_q;
  logic [W-1:0] x_nxt, y_nxt;

  logic s1_load, s2_load, out_xfer;

  assign s2_load      = s1_valid && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid || s2_load;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign out_xfer     = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;

  always_comb begin
    x_nxt = '0;
    y_nxt = '0;
    unique case (s1_mode)
      MODE_XNOR_OR: begin
        x_nxt = ~s1_c ^ (s1_a | s1_b);
        y_nxt = (s1_a | s1_b) & (~(s1_a & s1_b) ^ (s1_a | s1_b));
      end
      MODE_AND_XOR: begin
        x_nxt = s1_c ^ (s1_a & s1_b);
        y_nxt = s1_a ^ s1_b;
      end
      MODE_MAJ: begin
        x_nxt = (s1_a & s1_b) | (s1_a & s1_c) | (s1_b & s1_c);
        y_nxt = s1_a ^ s1_b ^ s1_c;
      end
      MODE_NOR: begin
        x_nxt = ~(s1_a | s1_b | s1_c);
        y_nxt = s1_a & s1_b & s1_c;
      end
      default: begin
        x_nxt = '0;
        y_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_mode  <= MODE_XNOR_OR;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_c     <= bus.c;
      s1_mode  <= mode_e'(bus.mode);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      x_q         <= x_nxt;
      y_q         <= y_nxt;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef LOGIC_EVAL_PARITY_EN
  logic x_par_q, y_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_par_q <= 1'b0;
      y_par_q <= 1'b0;
    end else if (s2_load) begin
      x_par_q <= ^x_nxt;
      y_par_q <= ^y_nxt;
    end
  end

  assign bus.x_par = x_par_q;
  assign bus.y_par = y_par_q;
`else
  assign bus.x_par = 1'b0;
  assign bus.y_par = 1'b0;
`endif

  // Sum is one bit wider than either operand so saturation is a plain compare.
  logic [PC_W-1:0]  x_pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [SUM_W-1:0] cnt_max;

  always_comb begin
    x_pop = '0;
    for (int unsigned i = 0; i < W; i++) begin
      x_pop = x_pop + PC_W'(x_q[i]);
    end
    cnt_max              = '0;
    cnt_max[CNT_W-1:0]   = '1;
    cnt_sum              = SUM_W'(x_ones_cnt) + SUM_W'(x_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_ones_cnt <= '0;
    end else if (clr_cnt) begin
      x_ones_cnt <= '0;
    end else if (out_xfer) begin
      x_ones_cnt <= (cnt_sum > cnt_max) ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: doc/logic_eval_pipe.md
# logic_eval_pipe

Parametrised, pipelined successor to the week-4 three-input gate network. It evaluates a selectable pair of bitwise functions x/y over W-bit vectors a, b, c. Results pass through a two-stage valid/ready pipeline with full backpressure, and a saturating counter tracks the number of ones delivered on x. It sits between a stimulus source (switches or a test driver) and any downstream consumer that may stall.

## Interface
- W, default 8: vector width of a, b, c, x, y.
- CNT_W, default 16: width of the ones counter.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a/b/c/mode are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- a, b, c  input  W each  operand vectors.
- mode  input  2  function select, sampled with the operands.
- out_valid  output  1  x/y hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- x, y  output  W each  result vectors.
- x_par, y_par  output  1 each  even-parity bits of x and y. Exist only under the parity macro; otherwise tied 0.
- clr_cnt  input  1  synchronous clear of x_ones_cnt.
- x_ones_cnt  output  CNT_W  saturating count of ones delivered on x.

## Operation
- Modes (bitwise, per bit):
  - 0: x = ~c ^ (a|b); y = (a|b) & (~(a&b) ^ (a|b)). This y reduces to a&b.
  - 1: x = c ^ (a&b); y = a ^ b.
  - 2: x = majority(a,b,c); y = a ^ b ^ c.
  - 3: x = ~(a|b|c); y = a & b & c.
- Stage 1 (S1) registers a, b, c and mode.
- Stage 2 (S2) registers the computed x/y. It computes from the S1 contents, not from live inputs.
- Handshake conditions:
  - s2_load = S1 valid && (!out_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load. This path is combinational from out_ready.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - x/y must hold stable while out_valid && !out_ready.
- Ordering: strict FIFO order, no loss, no duplication. Maximum occupancy is 2.
- Counter on each output transfer: x_ones_cnt += popcount(x), saturating at 2^CNT_W-1 with no wrap.
  - popcount is computed at W-derived width, then added with saturation.
  - clr_cnt set in the same cycle as a transfer: clear wins and the counter becomes 0.
- in_valid may drop without a transfer; no state changes in that case.

## Timing
- Reset (rst_n low, asynchronous, effective immediately):
  - s1_valid, out_valid = 0; x, y, x_par, y_par = 0; x_ones_cnt = 0; S1 data = 0.
  - in_ready = 1 while reset is low and after reset.
- Reset mid-operation discards both stages. out_valid falls without waiting for clk.
- Latency: input accepted at edge N gives out_valid = 1 after edge N+1, with x/y valid.
- Throughput: 1 result per cycle while out_ready is held 1.
- Stall: out_ready = 0 with both stages full drops in_ready to 0 in the same cycle.
- Release: out_ready rising returns in_ready to 1 in that same cycle (combinational pass-through).
- The counter updates on the edge that completes the output transfer. The new value is visible the following cycle.

## Configuration
- LOGIC_EVAL_PARITY_EN defined:
  - S2 also registers x_par = ^x and y_par = ^y. They load and hold with x/y and reset to 0.
- Not defined:
  - x_par and y_par are constant 0 and no parity logic is built.
  - All other behaviour is identical.

## Test plan
- Mode 0: W=8, a=0xF0, b=0xCC, c=0xAA, out_ready=1.
  - Expect x=0xA9 and y=0xC0 two edges after accept.
  - x_ones_cnt goes 0 -> 4. With the macro, x_par=0 and y_par=0.
- Modes 1/2, same operands:
  - Mode 1: x=0x6A, y=0x3C.
  - Mode 2: x=0xE8, y=0x96.
  - Issued back-to-back, they must emerge on consecutive cycles in issue order.
- Backpressure: stream 4 inputs with out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts; x/y stay stable.
  - After release, all 4 results appear in order with none duplicated.
- Saturation: CNT_W=4, mode 3, a=b=c=0 (x=0xFF), three transfers.
  - Count goes 8, then 15, then stays 15.
  - clr_cnt with a simultaneous transfer gives 0.
- Reset mid-stream: pull rst_n low with both stages full.
  - out_valid, x, y and x_ones_cnt are 0 before the next edge; in_ready=1.
  - The first input after release appears 2 edges later.
